// File: rtl/pipe_hazard_ctl_pkg.sv
// Shared definitions for the pipeline stall/flush controller and the
// benches of the pipeline registers it drives.
package pipe_ctl_pkg;

  localparam int REG_BITS  = 3;
  localparam int CNT_BITS  = 2;
  localparam int FLUSH_MAX = 3;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    MEM_WAIT = 3'd1,
    MEM_DONE = 3'd2,
    FLUSH    = 3'd3,
    HALT     = 3'd4
  } ctl_state_e;

endpackage

// File: rtl/pipe_hazard_ctl_if.sv
// Bundle between the pipeline stages (master) and the stall/flush
// controller (slave).
interface pipe_hazard_ctl_if #(
  parameter int REG_BITS = pipe_ctl_pkg::REG_BITS
);
  logic [REG_BITS-1:0] rs_ID;
  logic [REG_BITS-1:0] rt_ID;
  logic                rsUsed_ID;
  logic                rtUsed_ID;
  logic [REG_BITS-1:0] writeregsel_EX;
  logic                RegWrite_EX;
  logic                memRead_EX;
  logic                redirect_EX;
  logic                memBusy;
  logic                memReady;
  logic                isHalt_WB;

  logic                isAllStall;
  logic                isDataStall;
  logic                dependentLoad;
  logic                isFlush;
  logic                memDone;
  logic                memStall;

  modport master (
    output rs_ID, rt_ID, rsUsed_ID, rtUsed_ID, writeregsel_EX, RegWrite_EX,
           memRead_EX, redirect_EX, memBusy, memReady, isHalt_WB,
    input  isAllStall, isDataStall, dependentLoad, isFlush, memDone, memStall
  );

  modport slave (
    input  rs_ID, rt_ID, rsUsed_ID, rtUsed_ID, writeregsel_EX, RegWrite_EX,
           memRead_EX, redirect_EX, memBusy, memReady, isHalt_WB,
    output isAllStall, isDataStall, dependentLoad, isFlush, memDone, memStall
  );
endinterface

// File: rtl/pipe_hazard_ctl_hazard_cmp.sv
// Load-use comparator: the load in EX writes a register the ID
// instruction actually reads.
module hazard_cmp #(
  parameter int REG_BITS = pipe_ctl_pkg::REG_BITS
) (
  input  logic [REG_BITS-1:0] i_rs_id,
  input  logic [REG_BITS-1:0] i_rt_id,
  input  logic                i_rs_used_id,
  input  logic                i_rt_used_id,
  input  logic [REG_BITS-1:0] i_wr_sel_ex,
  input  logic                i_reg_write_ex,
  input  logic                i_mem_read_ex,
  output logic                o_hz
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = i_rs_used_id & (i_rs_id == i_wr_sel_ex);
  assign w_rt_hit = i_rt_used_id & (i_rt_id == i_wr_sel_ex);
  assign o_hz     = i_mem_read_ex & i_reg_write_ex & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Central stall/flush controller: load-use stall, multi-cycle memory
// wait sequencing, wrong-path squash after an EX redirect, and halt freeze.
module pipe_hazard_ctl
  import pipe_ctl_pkg::*;
#(
  parameter int REG_BITS     = pipe_ctl_pkg::REG_BITS,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctl_if.slave   bus
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > FLUSH_MAX) begin : g_bad_flush
    $error("pipe_hazard_ctl: FLUSH_CYCLES out of range 1..3");
  end

  localparam logic [CNT_BITS-1:0] C_FULL   = CNT_BITS'(FLUSH_CYCLES);
  localparam logic [CNT_BITS-1:0] C_RELOAD = CNT_BITS'(FLUSH_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] C_ONE    = CNT_BITS'(1);

  ctl_state_e          r_state;
  ctl_state_e          w_state_nxt;
  logic [CNT_BITS-1:0] r_cnt;
  logic [CNT_BITS-1:0] w_cnt_nxt;
  logic                r_pend;
  logic                w_pend_nxt;
  logic                r_resume;
  logic                w_resume_nxt;

  logic w_hz;
  logic w_all_stall;
  logic w_flush;
  logic w_mem_done;
  logic w_mem_stall;

  hazard_cmp #(.REG_BITS(REG_BITS)) u_hazard_cmp (
    .i_rs_id        (bus.rs_ID),
    .i_rt_id        (bus.rt_ID),
    .i_rs_used_id   (bus.rsUsed_ID),
    .i_rt_used_id   (bus.rtUsed_ID),
    .i_wr_sel_ex    (bus.writeregsel_EX),
    .i_reg_write_ex (bus.RegWrite_EX),
    .i_mem_read_ex  (bus.memRead_EX),
    .o_hz           (w_hz)
  );

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= RUN;
      r_cnt    <= '0;
      r_pend   <= 1'b0;
      r_resume <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pend   <= w_pend_nxt;
      r_resume <= w_resume_nxt;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_pend_nxt   = r_pend;
    w_resume_nxt = r_resume;
    w_all_stall  = 1'b0;
    w_flush      = 1'b0;
    w_mem_done   = 1'b0;
    w_mem_stall  = 1'b0;

    case (r_state)
      RUN: begin
        if (bus.isHalt_WB) begin
          w_state_nxt = HALT;
        end else if (bus.memBusy) begin
          w_all_stall  = 1'b1;
          w_pend_nxt   = bus.redirect_EX;
          w_resume_nxt = 1'b0;
          w_state_nxt  = MEM_WAIT;
        end else if (bus.redirect_EX) begin
          w_flush     = 1'b1;
          w_cnt_nxt   = C_RELOAD;
          w_state_nxt = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end
      end

      MEM_WAIT: begin
        w_all_stall = 1'b1;
        w_mem_stall = 1'b1;
        if (bus.redirect_EX) w_pend_nxt = 1'b1;
        if (bus.memReady)    w_state_nxt = MEM_DONE;
      end

      // A redirect seen during the wait restarts a full squash; an
      // interrupted squash only finishes its remaining count.
      MEM_DONE: begin
        w_all_stall  = 1'b1;
        w_mem_done   = 1'b1;
        w_resume_nxt = 1'b0;
        if (r_pend) begin
          w_pend_nxt  = 1'b0;
          w_cnt_nxt   = C_FULL;
          w_state_nxt = FLUSH;
        end else if (r_resume) begin
          w_state_nxt = FLUSH;
        end else begin
          w_state_nxt = RUN;
        end
      end

      FLUSH: begin
        if (bus.memBusy) begin
          w_all_stall  = 1'b1;
          w_resume_nxt = 1'b1;
          w_pend_nxt   = bus.redirect_EX;
          w_state_nxt  = MEM_WAIT;
        end else begin
          w_flush = 1'b1;
          if (bus.redirect_EX) begin
            w_cnt_nxt = C_RELOAD;
            if (C_RELOAD == '0) w_state_nxt = RUN;
          end else begin
            w_cnt_nxt = r_cnt - C_ONE;
            if (r_cnt == C_ONE) w_state_nxt = RUN;
          end
        end
      end

      HALT: begin
        w_all_stall = 1'b1;
      end

      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // Outputs are forced low for as long as reset is held, not just after an edge.
  assign bus.isAllStall    = rst & w_all_stall;
  assign bus.isFlush       = rst & w_flush;
  assign bus.memDone       = rst & w_mem_done;
  assign bus.memStall      = rst & w_mem_stall;
  assign bus.isDataStall   = rst & w_hz & ~w_all_stall & ~w_flush;
  assign bus.dependentLoad = bus.isDataStall;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Scoreboard bench for pipe_hazard_ctl: each step pushes the expected
// output vector and pops it when the outputs are sampled mid-cycle.
module tb_pipe_hazard_ctl;
  import pipe_ctl_pkg::*;

  // Output vector: {isAllStall, isDataStall, dependentLoad, isFlush, memDone, memStall}
  localparam logic [5:0] E_IDLE  = 6'b000000;
  localparam logic [5:0] E_HZ    = 6'b011000;
  localparam logic [5:0] E_ALL   = 6'b100000;
  localparam logic [5:0] E_FLUSH = 6'b000100;
  localparam logic [5:0] E_DONE  = 6'b100010;
  localparam logic [5:0] E_WAIT  = 6'b100001;

  // Control nibble: {isHalt_WB, redirect_EX, memBusy, memReady}
  localparam logic [3:0] C_NONE  = 4'b0000;
  localparam logic [3:0] C_RDY   = 4'b0001;
  localparam logic [3:0] C_BUSY  = 4'b0010;
  localparam logic [3:0] C_REDIR = 4'b0100;
  localparam logic [3:0] C_RB    = 4'b0110;
  localparam logic [3:0] C_HALT  = 4'b1000;

  typedef struct packed {
    logic [2:0] rs;
    logic [2:0] rt;
    logic [2:0] wr;
    logic       rsu;
    logic       rtu;
    logic       rw;
    logic       mr;
  } hz_t;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  logic [5:0] exp_q[$];
  string      tag_q[$];

  pipe_hazard_ctl_if #(.REG_BITS(REG_BITS)) bus ();

  pipe_hazard_ctl #(.REG_BITS(REG_BITS), .FLUSH_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic hz_t mk(input int rs, input int rt, input int wr,
                             input bit rsu, input bit rtu, input bit rw, input bit mr);
    hz_t h;
    h.rs  = 3'(rs);
    h.rt  = 3'(rt);
    h.wr  = 3'(wr);
    h.rsu = rsu;
    h.rtu = rtu;
    h.rw  = rw;
    h.mr  = mr;
    return h;
  endfunction

  function automatic logic [5:0] observed();
    return {bus.isAllStall, bus.isDataStall, bus.dependentLoad,
            bus.isFlush, bus.memDone, bus.memStall};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%b exp=%b", tag, got[5:0], exp[5:0]);
    end
  endtask

  task automatic drive(input hz_t h, input logic [3:0] c);
    bus.rs_ID          = h.rs;
    bus.rt_ID          = h.rt;
    bus.writeregsel_EX = h.wr;
    bus.rsUsed_ID      = h.rsu;
    bus.rtUsed_ID      = h.rtu;
    bus.RegWrite_EX    = h.rw;
    bus.memRead_EX     = h.mr;
    bus.isHalt_WB      = c[3];
    bus.redirect_EX    = c[2];
    bus.memBusy        = c[1];
    bus.memReady       = c[0];
  endtask

  // Called just after a rising edge; samples on the falling edge.
  task automatic step(input string tag, input hz_t h, input logic [3:0] c,
                      input logic [5:0] exp);
    logic [5:0] e;
    string      t;
    drive(h, c);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, {26'd0, observed()}, {26'd0, e});
    @(posedge clk);
    #1;
  endtask

  hz_t nil;
  hz_t ld_rs3;

  initial begin
    n_total = 0;
    n_bad   = 0;
    nil     = mk(0, 0, 0, 0, 0, 0, 0);
    ld_rs3  = mk(3, 5, 3, 1, 1, 1, 1);

    // Reset with a live load-use pattern: outputs still low.
    rst = 1'b0;
    drive(ld_rs3, C_BUSY);
    #12;
    check("reset_outputs", {26'd0, observed()}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Load-use
    step("lu_rs_hit",      ld_rs3,                    C_NONE, E_HZ);
    step("lu_bubble",      mk(3, 5, 3, 1, 1, 0, 0),   C_NONE, E_IDLE);
    step("lu_rt_hit",      mk(6, 3, 3, 1, 1, 1, 1),   C_NONE, E_HZ);
    step("lu_rt_bubble",   mk(6, 3, 3, 1, 1, 0, 0),   C_NONE, E_IDLE);
    step("lu_unused",      mk(3, 3, 3, 0, 0, 1, 1),   C_NONE, E_IDLE);
    step("lu_no_regwrite", mk(3, 3, 3, 1, 1, 0, 1),   C_NONE, E_IDLE);
    step("lu_not_load",    mk(3, 3, 3, 1, 1, 1, 0),   C_NONE, E_IDLE);
    step("lu_diff_reg",    mk(2, 4, 7, 1, 1, 1, 1),   C_NONE, E_IDLE);
    step("lu_reg0_hit",    mk(0, 1, 0, 1, 0, 1, 1),   C_NONE, E_HZ);

    // Memory wait: 4 busy cycles, then ready
    step("mem_busy0", ld_rs3, C_BUSY, E_ALL);
    for (int i = 1; i < 4; i++) step($sformatf("mem_wait%0d", i), nil, C_BUSY, E_WAIT);
    step("mem_ready", nil, C_RDY,  E_WAIT);
    step("mem_done",  nil, C_NONE, E_DONE);
    step("mem_run",   nil, C_NONE, E_IDLE);

    // Redirect in RUN: two flush cycles, load-use suppressed during flush
    step("fl_redirect", nil,    C_REDIR, E_FLUSH);
    step("fl_second",   ld_rs3, C_NONE,  E_FLUSH);
    step("fl_run",      nil,    C_NONE,  E_IDLE);

    // Redirect with memory busy: flush deferred until after memDone
    step("rb_enter",  nil, C_RB,   E_ALL);
    step("rb_wait",   nil, C_BUSY, E_WAIT);
    step("rb_ready",  nil, C_RDY,  E_WAIT);
    step("rb_done",   nil, C_NONE, E_DONE);
    step("rb_flush1", nil, C_NONE, E_FLUSH);
    step("rb_flush2", nil, C_NONE, E_FLUSH);
    step("rb_run",    nil, C_NONE, E_IDLE);

    // Flush interrupted by memory busy resumes with the held count
    step("fi_redirect", nil, C_REDIR, E_FLUSH);
    step("fi_busy",     nil, C_BUSY,  E_ALL);
    step("fi_ready",    nil, C_RDY,   E_WAIT);
    step("fi_done",     nil, C_NONE,  E_DONE);
    step("fi_resume",   nil, C_NONE,  E_FLUSH);
    step("fi_run",      nil, C_NONE,  E_IDLE);

    // Redirect while flushing reloads the count
    step("rl_first",  nil, C_REDIR, E_FLUSH);
    step("rl_again",  nil, C_REDIR, E_FLUSH);
    step("rl_last",   nil, C_NONE,  E_FLUSH);
    step("rl_run",    nil, C_NONE,  E_IDLE);

    // Halt: takes effect from the next cycle and sticks
    step("halt_enter", nil, C_HALT, E_IDLE);
    for (int i = 0; i < 10; i++) begin
      step($sformatf("halt_hold%0d", i), ld_rs3, (i % 2 == 0) ? C_REDIR : C_BUSY, E_ALL);
    end
    rst = 1'b0;
    #1;
    check("halt_async_reset", {26'd0, observed()}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step("halt_left", nil, C_NONE, E_IDLE);

    // Reset mid-wait: outputs drop at once, pending flush discarded
    step("rw_enter", nil, C_RB,   E_ALL);
    step("rw_wait",  nil, C_BUSY, E_WAIT);
    drive(ld_rs3, C_BUSY);
    #1;
    rst = 1'b0;
    #1;
    check("rw_async_reset", {26'd0, observed()}, 32'd0);
    @(posedge clk);
    #1;
    check("rw_reset_held", {26'd0, observed()}, 32'd0);
    rst = 1'b1;
    step("rw_run",      nil, C_RDY,  E_IDLE);
    step("rw_no_pend",  nil, C_NONE, E_IDLE);
    step("rw_lu_live",  ld_rs3, C_NONE, E_HZ);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
